// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default baud divisor and parity helper.
// Used by both the receiver and the transmitter.
package uart_pkg;

   localparam int CLK_DIV_19200 = 2604;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_state_e;

   // XOR over up to 8 data bits plus the parity bit; callers zero-extend narrower words.
   function automatic logic parity_of(input logic [8:0] bits);
      return ^bits;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator: down-counter ticking at zero, with full-bit and half-bit reload.
// Shared between the UART receiver and transmitter.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_19200
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic load_half,
   output logic tick
);

   localparam int                CNT_W  = $clog2(CLK_DIV + 1);
   localparam logic [CNT_W-1:0]  RELOAD = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0]  HALF   = CNT_W'(CLK_DIV / 2 - 1);

   logic [CNT_W-1:0] baud_cnt_q;
   logic [CNT_W-1:0] baud_cnt_d;

   assign tick = (baud_cnt_q == '0);

   always_comb begin
      baud_cnt_d = baud_cnt_q;
      if (load_half) begin
         baud_cnt_d = HALF;
      end else if (load || tick) begin
         baud_cnt_d = RELOAD;
      end else begin
         baud_cnt_d = baud_cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         baud_cnt_q <= '0;
      end else begin
         baud_cnt_q <= baud_cnt_d;
      end
   end

endmodule

// File: rtl/uart_rcv_cfg.sv
// Configurable UART receiver: synchronised RX, false-start rejection, optional parity,
// sticky holding register with framing/parity/overrun flags.
module uart_rcv_cfg
   import uart_pkg::*;
#(
   parameter int CLK_DIV    = CLK_DIV_19200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 RX,
   input  logic                 clr_rx_rdy,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_rdy,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun
);

   localparam logic       PEN      = (PARITY_EN != 0);
   localparam logic       ODD      = (PARITY_ODD != 0);
   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   logic rx_meta_q, rx_meta_d;
   logic rx_s_q,    rx_s_d;
   logic rx_prev_q, rx_prev_d;

   uart_state_e state_q, state_d;
   logic [2:0]           bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q,   shift_d;
   logic                 par_bit_q, par_bit_d;

   logic [DATA_BITS-1:0] rx_data_q,    rx_data_d;
   logic                 rx_rdy_q,     rx_rdy_d;
   logic                 frame_err_q,  frame_err_d;
   logic                 parity_err_q, parity_err_d;
   logic                 overrun_q,    overrun_d;

   logic load_half;
   logic tick;
   logic complete;

   uart_baud_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_baud (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (1'b0),
      .load_half (load_half),
      .tick      (tick)
   );

   assign rx_meta_d = RX;
   assign rx_s_d    = rx_meta_q;
   assign rx_prev_d = rx_s_q;

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_bit_d = par_bit_q;
      load_half = 1'b0;
      complete  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (rx_prev_q && !rx_s_q) begin
               load_half = 1'b1;
               state_d   = ST_START;
            end
         end
         ST_START: begin
            // A start bit that is high again at mid-bit is a glitch, not a frame.
            if (tick) begin
               if (rx_s_q) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d   = ST_DATA;
                  bit_cnt_d = '0;
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == LAST_BIT) begin
                  state_d = PEN ? ST_PARITY : ST_STOP;
               end
            end
         end
         ST_PARITY: begin
            if (tick) begin
               par_bit_d = rx_s_q;
               state_d   = ST_STOP;
            end
         end
         ST_STOP: begin
            if (tick) begin
               complete = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      rx_data_d    = rx_data_q;
      rx_rdy_d     = rx_rdy_q;
      frame_err_d  = frame_err_q;
      parity_err_d = parity_err_q;
      overrun_d    = overrun_q;

      if (clr_rx_rdy) begin
         rx_rdy_d  = 1'b0;
         overrun_d = 1'b0;
      end

      // A coincident clear consumes the old word, so it cannot count as an overrun.
      if (complete) begin
         rx_data_d    = shift_q;
         rx_rdy_d     = 1'b1;
         frame_err_d  = ~rx_s_q;
         parity_err_d = PEN & (parity_of(9'({shift_q, par_bit_q})) != ODD);
         overrun_d    = ~clr_rx_rdy & (overrun_q | rx_rdy_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_meta_q    <= 1'b1;
         rx_s_q       <= 1'b1;
         rx_prev_q    <= 1'b1;
         state_q      <= ST_IDLE;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         par_bit_q    <= 1'b0;
         rx_data_q    <= '0;
         rx_rdy_q     <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         rx_meta_q    <= rx_meta_d;
         rx_s_q       <= rx_s_d;
         rx_prev_q    <= rx_prev_d;
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         par_bit_q    <= par_bit_d;
         rx_data_q    <= rx_data_d;
         rx_rdy_q     <= rx_rdy_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign rx_data    = rx_data_q;
   assign rx_rdy     = rx_rdy_q;
   assign frame_err  = frame_err_q;
   assign parity_err = parity_err_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rcv_cfg.sv
// Directed bench for uart_rcv_cfg: an 8N1 instance and an even-parity instance at CLK_DIV=16.
module tb_uart_rcv_cfg;

   localparam int CD = 16;

   logic       clk;
   logic       rst_n;
   logic       rx_a, rx_b;
   logic       clr_a, clr_b;
   logic [7:0] data_a, data_b;
   logic       rdy_a, rdy_b;
   logic       fe_a, fe_b;
   logic       pe_a, pe_b;
   logic       ovr_a, ovr_b;

   int n_chk  = 0;
   int n_pass = 0;

   uart_rcv_cfg #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .RX(rx_a), .clr_rx_rdy(clr_a),
      .rx_data(data_a), .rx_rdy(rdy_a), .frame_err(fe_a), .parity_err(pe_a), .overrun(ovr_a)
   );

   uart_rcv_cfg #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .RX(rx_b), .clr_rx_rdy(clr_b),
      .rx_data(data_b), .rx_rdy(rdy_b), .frame_err(fe_b), .parity_err(pe_b), .overrun(ovr_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       sel;
      logic [7:0] data;
      logic       par;
      logic       stop;
      logic [7:0] exp_data;
      logic       exp_fe;
      logic       exp_pe;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic drive(input logic sel, input logic v);
      if (sel) rx_b = v;
      else     rx_a = v;
   endtask

   task automatic send_frame(input logic sel, input logic [7:0] d, input logic has_par,
                             input logic par, input logic stop_b);
      drive(sel, 1'b0);
      repeat (CD) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         drive(sel, d[i]);
         repeat (CD) @(negedge clk);
      end
      if (has_par) begin
         drive(sel, par);
         repeat (CD) @(negedge clk);
      end
      drive(sel, stop_b);
      repeat (CD) @(negedge clk);
      drive(sel, 1'b1);
   endtask

   task automatic clr_pulse(input logic sel);
      @(negedge clk);
      if (sel) clr_b = 1'b1; else clr_a = 1'b1;
      @(negedge clk);
      clr_a = 1'b0;
      clr_b = 1'b0;
   endtask

   vec_t vecs [8];
   int   lat;

   initial begin
      rst_n = 1'b0;
      rx_a  = 1'b1;
      rx_b  = 1'b1;
      clr_a = 1'b0;
      clr_b = 1'b0;

      vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 8'h55, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 8'h03, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 8'h03, 1'b1, 1'b1, 8'h03, 1'b0, 1'b1};
      vecs[5] = '{1'b1, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
      vecs[6] = '{1'b1, 8'h80, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
      vecs[7] = '{1'b1, 8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_data_a", data_a, 0);
      check("reset_rdy_a",  rdy_a,  0);
      check("reset_fe_a",   fe_a,   0);
      check("reset_pe_a",   pe_a,   0);
      check("reset_ovr_a",  ovr_a,  0);
      check("reset_rdy_b",  rdy_b,  0);
      check("reset_pe_b",   pe_b,   0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      for (int v = 0; v < 8; v++) begin
         clr_pulse(vecs[v].sel);
         repeat (4) @(negedge clk);
         send_frame(vecs[v].sel, vecs[v].data, vecs[v].sel, vecs[v].par, vecs[v].stop);
         if (vecs[v].sel) begin
            check($sformatf("vec%0d_data", v), data_b, vecs[v].exp_data);
            check($sformatf("vec%0d_rdy", v),  rdy_b,  1);
            check($sformatf("vec%0d_fe", v),   fe_b,   vecs[v].exp_fe);
            check($sformatf("vec%0d_pe", v),   pe_b,   vecs[v].exp_pe);
            check($sformatf("vec%0d_ovr", v),  ovr_b,  0);
         end else begin
            check($sformatf("vec%0d_data", v), data_a, vecs[v].exp_data);
            check($sformatf("vec%0d_rdy", v),  rdy_a,  1);
            check($sformatf("vec%0d_fe", v),   fe_a,   vecs[v].exp_fe);
            check($sformatf("vec%0d_pe", v),   pe_a,   vecs[v].exp_pe);
            check($sformatf("vec%0d_ovr", v),  ovr_a,  0);
         end
         repeat (8) @(negedge clk);
      end

      // Latency from start edge to rx_rdy: 16*9.5+4 = 156 (+/-1)
      clr_pulse(1'b0);
      repeat (4) @(negedge clk);
      lat = 0;
      fork
         send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
         begin
            while (!rdy_a && lat < 400) begin
               @(posedge clk);
               #1;
               lat++;
            end
         end
      join
      check("latency_window", (lat >= 155 && lat <= 157) ? lat : 0, lat);
      if (!(lat >= 155 && lat <= 157)) $display("  latency was %0d clks, window 155..157", lat);
      check("latency_data", data_a, 8'hA5);

      // Short low glitch must be rejected
      clr_pulse(1'b0);
      repeat (4) @(negedge clk);
      rx_a = 1'b0;
      repeat (6) @(negedge clk);
      rx_a = 1'b1;
      repeat (40) @(negedge clk);
      check("glitch_rdy", rdy_a, 0);
      check("glitch_fe",  fe_a,  0);
      check("glitch_ovr", ovr_a, 0);
      send_frame(1'b0, 8'h96, 1'b0, 1'b0, 1'b1);
      check("post_glitch_data", data_a, 8'h96);
      check("post_glitch_rdy",  rdy_a,  1);

      // Back-to-back frames without consuming
      clr_pulse(1'b0);
      repeat (4) @(negedge clk);
      send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
      send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
      check("b2b_data", data_a, 8'h22);
      check("b2b_rdy",  rdy_a,  1);
      check("b2b_ovr",  ovr_a,  1);
      clr_pulse(1'b0);
      check("clr_rdy",  rdy_a,  0);
      check("clr_ovr",  ovr_a,  0);
      check("clr_data", data_a, 8'h22);

      // Reset in the middle of the data bits
      send_frame(1'b0, 8'h77, 1'b0, 1'b0, 1'b1);
      check("pre_rst_rdy", rdy_a, 1);
      repeat (4) @(negedge clk);
      rx_a = 1'b0;
      repeat (CD) @(negedge clk);
      rx_a = 1'b1;
      repeat (CD) @(negedge clk);
      rx_a = 1'b0;
      repeat (CD) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_rdy",  rdy_a,  0);
      check("midrst_data", data_a, 0);
      check("midrst_fe",   fe_a,   0);
      check("midrst_ovr",  ovr_a,  0);
      repeat (2) @(negedge clk);
      rx_a  = 1'b1;
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check("after_rst_rdy", rdy_a, 0);
      send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
      check("after_rst_data", data_a, 8'h3C);
      check("after_rst_rdy2", rdy_a,  1);
      check("after_rst_fe",   fe_a,   0);
      check("after_rst_ovr",  ovr_a,  0);

      // clr_rx_rdy on the completion edge: completion wins, no overrun
      repeat (4) @(negedge clk);
      fork
         send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
         begin
            repeat (154) @(posedge clk);
            @(negedge clk);
            clr_a = 1'b1;
            @(posedge clk);
            #1;
            clr_a = 1'b0;
         end
      join
      check("coinc_data", data_a, 8'h5A);
      check("coinc_rdy",  rdy_a,  1);
      check("coinc_ovr",  ovr_a,  0);
      repeat (4) @(negedge clk);
      send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
      check("after_coinc_ovr",  ovr_a,  1);
      check("after_coinc_data", data_a, 8'h81);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
